risc32_debug_ctrl: RTL and testbench

//  Hardware single-step/debug controller for Risc32: the in-silicon replacement for bench-driven

---
 rtl/risc32_debug_ctrl_pkg.sv | 32 +++
 rtl/risc32_debug_ctrl_if.sv | 22 ++
 rtl/risc32_debug_ctrl.sv | 161 ++++++++++++++++
 tb/tb_risc32_debug_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc32_debug_ctrl_pkg.sv
// Shared encodings for the Risc32 debug controller: host opcodes, FSM states,
// halt-cause codes and the byte-address to word-index helper.
package risc32_dbg_pkg;

  localparam logic [2:0] OP_STATUS  = 3'd0;
  localparam logic [2:0] OP_HALT    = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_RUN     = 3'd3;
  localparam logic [2:0] OP_WR_IMEM = 3'd4;
  localparam logic [2:0] OP_WR_DMEM = 3'd5;
  localparam logic [2:0] OP_RD_REG  = 3'd6;
  localparam logic [2:0] OP_SET_BRK = 3'd7;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_BRK   = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_HALT  = 2'd3;

  typedef enum logic [2:0] {
    ST_HALTED,
    ST_STEP,
    ST_RUN,
    ST_RDREG,
    ST_RESP
  } state_e;

  // Upper address bits wrap: only addr[row+1:2] survives.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned row);
    return (addr >> 2) & ((32'd1 << row) - 32'd1);
  endfunction

endpackage

// File: rtl/risc32_debug_ctrl_if.sv
// Host command/response link of the debug controller.
interface risc32_debug_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/risc32_debug_ctrl.sv
// Risc32 single-step/debug controller: executes host commands, gates the datapath
// clock-enable for step/run, loads memories and reads registers back.
module risc32_debug_ctrl
  import risc32_dbg_pkg::*;
#(
  parameter int unsigned ROW_I = 4,
  parameter int unsigned ROW_D = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc32_debug_ctrl_if.slave   host,
  output logic                 cpu_en,
  input  logic [31:0]          pc_current,
  output logic                 imem_we,
  output logic                 dmem_we,
  output logic [31:0]          mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic [4:0]           dbg_reg_addr,
  input  logic [31:0]          dbg_reg_data
);

  state_e      state_q, state_d;
  logic        rdy_q, run_q, run_d, first_q, step_q;
  logic        brk_en_q;
  logic [31:0] brk_addr_q, limit_q, count_q;
  logic [1:0]  cause_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        imem_we_q, dmem_we_q;
  logic [31:0] waddr_q, wdata_q;
  logic [4:0]  reg_addr_q;

  logic        acc, halt_acc, brk_hit, lim_hit, stop;
  logic [31:0] status_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HALTED;
    else        state_q <= state_d;
  end

  always_comb begin
    run_d = run_q;
    if (stop || halt_acc) run_d = 1'b0;
    if (state_q == ST_HALTED && acc && host.cmd_op == OP_RUN) run_d = 1'b1;

    state_d = state_q;
    unique case (state_q)
      ST_HALTED: if (acc) begin
        unique case (host.cmd_op)
          OP_STEP:   state_d = ST_STEP;
          OP_RD_REG: state_d = ST_RDREG;
          default:   state_d = ST_RESP;
        endcase
      end
      ST_STEP:  if (step_q) state_d = ST_RESP;
      ST_RDREG: state_d = ST_RESP;
      ST_RUN: begin
        if (acc)       state_d = ST_RESP;
        else if (stop) state_d = ST_HALTED;
      end
      ST_RESP:  if (host.rsp_ready) state_d = run_d ? ST_RUN : ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    host.cmd_ready = rdy_q && (state_q == ST_HALTED || state_q == ST_RUN);
    acc            = host.cmd_valid && host.cmd_ready;
    halt_acc       = acc && state_q == ST_RUN && host.cmd_op == OP_HALT;
    // The first run cycle ignores the breakpoint so a run parked on it makes progress.
    brk_hit        = brk_en_q && (pc_current == brk_addr_q) && !first_q;
    lim_hit        = (limit_q != '0) && (count_q == limit_q);
    stop           = run_q && (brk_hit || lim_hit);
    cpu_en         = (run_q && !stop && !halt_acc) || (state_q == ST_STEP && !step_q);
    status_w       = {28'b0, cause_q, brk_en_q, run_q};
    host.rsp_valid = (state_q == ST_RESP);
    host.rsp_data  = rsp_data_q;
    host.rsp_err   = rsp_err_q;
    imem_we        = imem_we_q;
    dmem_we        = dmem_we_q;
    mem_waddr      = waddr_q;
    mem_wdata      = wdata_q;
    dbg_reg_addr   = reg_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      run_q      <= 1'b0;
      first_q    <= 1'b0;
      step_q     <= 1'b0;
      brk_en_q   <= 1'b0;
      brk_addr_q <= '0;
      limit_q    <= '0;
      count_q    <= '0;
      cause_q    <= CAUSE_NONE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      reg_addr_q <= '0;
    end else begin
      rdy_q     <= 1'b1;
      run_q     <= run_d;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      step_q    <= (state_q == ST_STEP) && !step_q;
      if (run_q) first_q <= 1'b0;
      if (cpu_en && run_q && count_q != '1) count_q <= count_q + 32'd1;

      if (halt_acc)  cause_q <= CAUSE_HALT;
      else if (stop) cause_q <= brk_hit ? CAUSE_BRK : CAUSE_LIMIT;

      // Step response is captured one cycle after the enable so the PC has advanced.
      if (state_q == ST_STEP && step_q) rsp_data_q <= pc_current;
      if (state_q == ST_RDREG) rsp_data_q <= (reg_addr_q == 5'd0) ? '0 : dbg_reg_data;

      if (acc) begin
        rsp_err_q  <= 1'b0;
        rsp_data_q <= '0;
        if (state_q == ST_HALTED) begin
          unique case (host.cmd_op)
            OP_STATUS:  rsp_data_q <= status_w;
            OP_WR_IMEM: begin
              imem_we_q  <= 1'b1;
              waddr_q    <= word_idx(host.cmd_addr, ROW_I);
              wdata_q    <= host.cmd_data;
              rsp_data_q <= word_idx(host.cmd_addr, ROW_I);
            end
            OP_WR_DMEM: begin
              dmem_we_q  <= 1'b1;
              waddr_q    <= word_idx(host.cmd_addr, ROW_D);
              wdata_q    <= host.cmd_data;
              rsp_data_q <= word_idx(host.cmd_addr, ROW_D);
            end
            OP_RUN: begin
              limit_q <= host.cmd_data;
              count_q <= '0;
              first_q <= 1'b1;
            end
            OP_RD_REG:  reg_addr_q <= host.cmd_addr[4:0];
            OP_SET_BRK: begin
              brk_addr_q <= host.cmd_addr;
              brk_en_q   <= (host.cmd_data != '0);
            end
            default: ;
          endcase
        end else begin
          unique case (host.cmd_op)
            OP_STATUS: rsp_data_q <= status_w;
            OP_HALT:   ;
            default:   rsp_err_q <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_risc32_debug_ctrl.sv
// Directed/randomized bench for risc32_debug_ctrl with a simple PC/memory/regfile
// environment and arithmetic prediction of run outcomes.
module tb_risc32_debug_ctrl;

  localparam logic [2:0] C_STATUS = 3'd0, C_HALT = 3'd1, C_STEP = 3'd2, C_RUN = 3'd3;
  localparam logic [2:0] C_WRI = 3'd4, C_WRD = 3'd5, C_RDREG = 3'd6, C_BRK = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  risc32_debug_ctrl_if bus();

  logic        cpu_en, imem_we, dmem_we;
  logic [31:0] pc_current, mem_waddr, mem_wdata, dbg_reg_data;
  logic [4:0]  dbg_reg_addr;

  risc32_debug_ctrl #(.ROW_I(4), .ROW_D(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (bus),
    .cpu_en       (cpu_en),
    .pc_current   (pc_current),
    .imem_we      (imem_we),
    .dmem_we      (dmem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
  );

  logic [31:0] pc = 32'd0;
  logic [31:0] imem [16];
  logic [31:0] dmem [32];
  logic [31:0] regs [32];
  int unsigned en_cnt = 0;
  int unsigned bad_addr = 0;
  int checks = 0;
  int failures = 0;

  assign pc_current   = pc;
  assign dbg_reg_data = regs[dbg_reg_addr];

  always @(posedge clk) begin
    if (cpu_en) begin
      pc     <= pc + 32'd4;
      en_cnt <= en_cnt + 1;
    end
    if (imem_we) begin
      if (mem_waddr < 32'd16) imem[mem_waddr[3:0]] <= mem_wdata;
      else bad_addr <= bad_addr + 1;
    end
    if (dmem_we) begin
      if (mem_waddr < 32'd32) dmem[mem_waddr[4:0]] <= mem_wdata;
      else bad_addr <= bad_addr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_wait", {31'b0, bus.rsp_valid}, 32'd1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        re;
    send(op, a, d);
    recv(rd, re);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, {31'b0, re}, {31'b0, exp_e});
  endtask

  // Instructions executed and halt cause of a run from p with breakpoint b and limit lim.
  function automatic void predict(input logic [31:0] p, input logic [31:0] b, input logic be,
                                  input logic [31:0] lim, output int unsigned steps,
                                  output logic [1:0] cause);
    logic [31:0] k;
    logic        reach;
    k     = (b - p) >> 2;
    reach = be && (b > p) && ((b - p) % 32'd4 == 32'd0);
    if (reach && (lim == 32'd0 || k <= lim)) begin
      steps = k; cause = 2'd1;
    end else begin
      steps = lim; cause = 2'd2;
    end
  endfunction

  function automatic logic [31:0] status(input logic [1:0] cause, input logic be, input logic run);
    return ({30'b0, cause} << 2) | ({31'b0, be} << 1) | {31'b0, run};
  endfunction

  task automatic wait_halt();
    int n = 0;
    @(negedge clk);
    while (cpu_en && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("run_ends", {31'b0, cpu_en}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, p, b, lim, idx, saved, rd;
    logic        re, be;
    logic [1:0]  m_cause, c;
    int unsigned en0, steps, r, k;

    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom | 32'd1;
    for (int i = 0; i < 16; i++) imem[i] = '0;
    for (int i = 0; i < 32; i++) dmem[i] = '0;

    #12;
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_we", {30'b0, imem_we, dmem_we}, 32'd0);
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, bus.cmd_ready}, 32'd1);
    cmd("status0", C_STATUS, '0, '0, 32'd0, 1'b0);
    m_cause = 2'd0;

    for (int i = 0; i < 10; i++) begin
      a = $urandom; d = $urandom;
      if (i % 2 == 0) begin
        idx = (a >> 2) % 32'd16;
        cmd("wr_imem", C_WRI, a, d, idx, 1'b0);
        chk("imem_word", imem[idx[3:0]], d);
      end else begin
        idx = (a >> 2) % 32'd32;
        cmd("wr_dmem", C_WRD, a, d, idx, 1'b0);
        chk("dmem_word", dmem[idx[4:0]], d);
      end
    end
    cmd("wr_dmem_128", C_WRD, 32'd128, 32'hf7f77f7f, 32'd0, 1'b0);
    chk("dmem_wrap", dmem[0], 32'hf7f77f7f);
    cmd("wr_dmem_124", C_WRD, 32'd124, 32'h00007f7f, 32'd31, 1'b0);
    chk("dmem_top", dmem[31], 32'h00007f7f);

    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 0 : $urandom_range(1, 31);
      cmd("rd_reg", C_RDREG, r, '0, (r == 0) ? 32'd0 : regs[r], 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      p = pc; en0 = en_cnt;
      cmd("step", C_STEP, '0, '0, p + 32'd4, 1'b0);
      chk("step_en_cycles", en_cnt - en0, 32'd1);
    end

    for (int i = 0; i < 8; i++) begin
      p = pc; en0 = en_cnt;
      k = $urandom_range(1, 20);
      be = (i != 6);
      b = (i == 4) ? p : p + 4 * k;
      case (i % 4)
        0: lim = 32'd0;
        1: lim = $urandom_range(1, 25);
        2: lim = k;
        default: lim = $urandom_range(1, 12);
      endcase
      if (b == p || !be) lim = $urandom_range(1, 12);
      cmd("set_brk", C_BRK, b, be ? ($urandom | 32'd1) : 32'd0, 32'd0, 1'b0);
      cmd("run_ack", C_RUN, '0, lim, 32'd0, 1'b0);
      wait_halt();
      predict(p, b, be, lim, steps, c);
      m_cause = c;
      chk("run_pc", pc, p + 4 * steps);
      chk("run_en_cycles", en_cnt - en0, steps);
      cmd("run_status", C_STATUS, '0, '0, status(m_cause, be, 1'b0), 1'b0);
    end

    cmd("brk_off", C_BRK, '0, '0, 32'd0, 1'b0);
    p = pc; en0 = en_cnt;
    cmd("run_free", C_RUN, '0, 32'd0, 32'd0, 1'b0);
    a = $urandom; idx = (a >> 2) % 32'd16; saved = imem[idx[3:0]];
    send(C_WRI, a, ~saved);
    recv(rd, re);
    chk("run_wr_err", {31'b0, re}, 32'd1);
    chk("run_wr_nochange", imem[idx[3:0]], saved);
    cmd("run_status_live", C_STATUS, '0, '0, status(m_cause, 1'b0, 1'b1), 1'b0);
    @(negedge clk);
    chk("cpu_en_running", {31'b0, cpu_en}, 32'd1);
    bus.cmd_op = C_HALT; bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_valid = 1'b1;
    #1 chk("halt_drops_en", {31'b0, cpu_en}, 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    recv(rd, re);
    chk("halt_err", {31'b0, re}, 32'd0);
    chk("halt_pc_consistent", pc - p, 4 * (en_cnt - en0));
    cmd("halt_status", C_STATUS, '0, '0, status(2'd3, 1'b0, 1'b0), 1'b0);

    send(C_STATUS, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("hold_data", bus.rsp_data, status(2'd3, 1'b0, 1'b0));
      chk("hold_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    recv(rd, re);
    chk("hold_final", rd, status(2'd3, 1'b0, 1'b0));

    cmd("run_rst", C_RUN, '0, 32'd0, 32'd0, 1'b0);
    send(C_STATUS, '0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run_en", {31'b0, cpu_en}, 32'd0);
    chk("rst_run_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", {31'b0, bus.cmd_ready}, 32'd1);
    cmd("status_after_rst", C_STATUS, '0, '0, 32'd0, 1'b0);
    chk("no_bad_addr", bad_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
